// File: rtl/instr_mem_loader_pkg.sv
// instr_mem_loader_pkg: shared instruction-memory constants and loader state encoding.
package instr_mem_loader_pkg;
    localparam int INSTR_W     = 16;
    localparam int BYTE_W      = 8;
    localparam int IMEM_ADDR_W = 10;
    localparam int IMEM_DEPTH  = 1024;
    typedef enum logic [3:0] {
        IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHK, DONE, ERR
    } state_t;
endpackage

// File: rtl/instr_mem_loader_word_assembler.sv
// instr_mem_loader_word_assembler: latches the HI byte and packs {hi,lo} into an instruction word.
module instr_mem_loader_word_assembler
    import instr_mem_loader_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hi_en,
    input  logic               lo_en,
    input  logic [BYTE_W-1:0]  in_byte,
    output logic [INSTR_W-1:0] word
);
    logic [BYTE_W-1:0] hi;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi   <= '0;
            word <= '0;
        end else begin
            if (hi_en) hi <= in_byte;
            if (lo_en) word <= {hi, in_byte};
        end
    end
endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: frames a host byte stream into 16-bit words and writes them to instruction memory.
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int ADDR_W    = IMEM_ADDR_W,
    parameter int MAX_WORDS = IMEM_DEPTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [BYTE_W-1:0]  in_byte,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               mem_we,
    output logic [15:0]        mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               busy,
    output logic               cpu_stall,
    output logic               done,
    output logic               error
);
    state_t state, nxt;
    logic xfer;
    logic [15:0] n, index, len;
    logic [BYTE_W-1:0] len_hi, chk;
    logic [ADDR_W-1:0] addr;

    assign in_ready  = state inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK};
    assign xfer      = in_valid && in_ready;
    assign len       = {len_hi, in_byte};
    assign mem_we    = state == WRITE;
    assign mem_addr  = 16'(addr);
    assign busy      = state != IDLE;
    assign cpu_stall = busy;
    assign done      = state == DONE;
    assign error     = state == ERR;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? LEN_HI : IDLE;
            LEN_HI:  nxt = xfer ? LEN_LO : LEN_HI;
            LEN_LO:  nxt = !xfer ? LEN_LO : len > 16'(MAX_WORDS) ? ERR : len == '0 ? CHK : DATA_HI;
            DATA_HI: nxt = xfer ? DATA_LO : DATA_HI;
            DATA_LO: nxt = xfer ? WRITE : DATA_LO;
            WRITE:   nxt = index + 16'd1 == n ? CHK : DATA_HI;
            CHK:     nxt = !xfer ? CHK : in_byte == chk ? DONE : ERR;
            default: nxt = IDLE;
        endcase
    end

    // The address is captured with the LO byte so it stays stable through and after WRITE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            n      <= '0;
            index  <= '0;
            len_hi <= '0;
            chk    <= '0;
            addr   <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE && start) begin
                index <= '0;
                chk   <= '0;
            end
            if (xfer && state != CHK) chk <= chk ^ in_byte;
            if (xfer && state == LEN_HI) len_hi <= in_byte;
            if (xfer && state == LEN_LO) n <= len;
            if (xfer && state == DATA_LO) addr <= index[ADDR_W-1:0];
            if (state == WRITE) index <= index + 16'd1;
        end
    end

    instr_mem_loader_word_assembler u_asm (
        .clk     (clk),
        .rst_n   (rst_n),
        .hi_en   (xfer && state == DATA_HI),
        .lo_en   (xfer && state == DATA_LO),
        .in_byte (in_byte),
        .word    (mem_wdata)
    );
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: scoreboard bench for the instruction-memory loader.
module tb_instr_mem_loader;
    logic        clk = 0, rst_n = 0, start = 0, in_valid = 0;
    logic [7:0]  in_byte = 0;
    logic        in_ready, mem_we, busy, cpu_stall, done, error;
    logic [15:0] mem_addr, mem_wdata;
    int checks = 0, errors = 0, cyc = 0;
    int start_cyc = 0, done_cyc = 0, err_cyc = 0, done_cnt = 0, err_cnt = 0, we_cnt = 0;
    logic [31:0] exp_q[$];
    logic [15:0] words[$];

    instr_mem_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_byte(in_byte), .in_valid(in_valid),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .cpu_stall(cpu_stall), .done(done), .error(error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (error) begin err_cnt++; err_cyc = cyc; end
        if (mem_we) begin
            we_cnt++;
            check("ready_in_write", 32'(in_ready), 0);
            if (exp_q.size() == 0) check("write_queued", 32'(exp_q.size()), 1);
            else check("write", {mem_addr, mem_wdata}, exp_q.pop_front());
        end
    end

    task automatic pulse_start(input bit rec);
        start = 1;
        if (rec) start_cyc = cyc;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic send(input logic [7:0] b, input bit gaps);
        int k;
        if (gaps && $urandom_range(0, 2) == 0) begin
            in_valid = 0;
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        end
        in_byte = b;
        in_valid = 1;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 100) begin @(negedge clk); k++; end
        if (!in_ready) check("ready_timeout", 32'(k), 0);
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic frame(input logic [7:0] flip, input bit gaps);
        logic [7:0] c;
        logic [15:0] n;
        n = 16'(words.size());
        c = n[15:8] ^ n[7:0];
        pulse_start(1);
        send(n[15:8], gaps);
        send(n[7:0], gaps);
        foreach (words[i]) begin
            if (gaps && i == 2) pulse_start(0);
            exp_q.push_back({16'(i), words[i]});
            send(words[i][15:8], gaps);
            send(words[i][7:0], gaps);
            c ^= words[i][15:8] ^ words[i][7:0];
        end
        send(c ^ flip, gaps);
    endtask

    task automatic wait_end(input int d0, input int e0);
        int k = 0;
        while (done_cnt == d0 && err_cnt == e0 && k < 500) begin @(posedge clk); k++; end
        if (k >= 500) check("end_timeout", 32'(k), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test(input string tag, input logic [7:0] flip, input bit gaps,
                        input int exp_done, input int exp_err, input int exp_lat);
        int d0, e0, w0;
        d0 = done_cnt; e0 = err_cnt; w0 = we_cnt;
        frame(flip, gaps);
        wait_end(d0, e0);
        check({tag, "_writes"}, 32'(we_cnt - w0), 32'(words.size()));
        check({tag, "_done"}, 32'(done_cnt - d0), 32'(exp_done));
        check({tag, "_error"}, 32'(err_cnt - e0), 32'(exp_err));
        check({tag, "_pending"}, 32'(exp_q.size()), 0);
        check({tag, "_idle"}, {30'b0, busy, cpu_stall}, 0);
        if (exp_lat > 0)
            check({tag, "_latency"}, 32'((exp_done > 0 ? done_cyc : err_cyc) - start_cyc + 1), 32'(exp_lat));
    endtask

    initial begin
        int d0, e0, w0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", {9'b0, in_ready, mem_we, busy, cpu_stall, done, error, 1'b0, mem_addr}, 0);
        check("reset_wdata", 32'(mem_wdata), 0);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;

        words = '{16'h2009, 16'h200A, 16'h012A, 16'h012B, 16'h014B, 16'h014B, 16'h016A};
        test("load7", 8'h00, 0, 1, 0, 26);
        words = {};
        test("zero", 8'h00, 0, 1, 0, 5);
        words = '{16'h2009, 16'h200A, 16'h012A, 16'h012B, 16'h014B, 16'h014B, 16'h016A};
        test("badchk", 8'h01, 0, 0, 1, 26);

        d0 = done_cnt; e0 = err_cnt; w0 = we_cnt;
        pulse_start(1);
        send(8'h04, 0);
        send(8'h01, 0);
        wait_end(d0, e0);
        check("len1025_error", 32'(err_cnt - e0), 1);
        check("len1025_done", 32'(done_cnt - d0), 0);
        check("len1025_writes", 32'(we_cnt - w0), 0);
        check("len1025_latency", 32'(err_cyc - start_cyc + 1), 4);
        words = '{16'h1111, 16'hFEDC, 16'h0F0F};
        test("after_len_err", 8'h00, 0, 1, 0, 14);

        words = '{16'h2009, 16'h200A, 16'h012A, 16'h012B, 16'h014B, 16'h014B, 16'h016A};
        test("gaps", 8'h00, 1, 1, 0, 0);

        pulse_start(1);
        send(8'h00, 0);
        send(8'h07, 0);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({16'(i), words[i]});
            send(words[i][15:8], 0);
            send(words[i][7:0], 0);
        end
        @(negedge clk); #1;
        check("we_before_reset", 32'(mem_we), 1);
        rst_n = 0;
        #1;
        check("midreset_outs", {9'b0, in_ready, mem_we, busy, cpu_stall, done, error, 1'b0, mem_addr}, 0);
        check("midreset_wdata", 32'(mem_wdata), 0);
        check("midreset_pending", 32'(exp_q.size()), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        words = '{16'hABCD, 16'h1234};
        test("fresh", 8'h00, 0, 1, 0, 11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
Writer side of the instruction memory. It takes a byte stream from a host link (UART/debug bridge) over a valid/ready handshake and frames it into 16-bit instruction words. Each word is written into the instruction memory's write port at consecutive addresses starting at 0. While loading, the block holds the CPU stalled, then signals done or error.

Parameters:
ADDR_W, 10, word-address bits actually decoded by instruction memory (depth 2**ADDR_W = 1024)
MAX_WORDS, 1024, largest accepted word count; must be <= 2**ADDR_W

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse that begins a load; ignored unless IDLE
in_byte  input  8  stream byte
in_valid  input  1  in_byte valid
in_ready  output  1  loader accepts in_byte this cycle
mem_we  output  1  instruction memory write strobe, one cycle per word
mem_addr  output  16  word address, bits [15:ADDR_W] always 0
mem_wdata  output  16  instruction word
busy  output  1  load in progress
cpu_stall  output  1  equals busy; holds the CPU PC/fetch
done  output  1  one-cycle pulse, successful load
error  output  1  one-cycle pulse, failed load

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0, including mem_addr and mem_wdata. Internal count, index and checksum registers are cleared.
- A byte transfers on a rising edge with in_valid && in_ready. in_valid without in_ready holds the byte; the loader never drops a byte.
- Frame format, big-endian: LEN_HI, LEN_LO, then N words sent as HI,LO byte pairs, then CHK. CHK is the XOR of every preceding frame byte, including the length bytes.
- States and transitions:
  - IDLE: in_ready=0. On start, clear index and checksum, then go to LEN_HI.
  - LEN_HI: in_ready=1. On transfer, store the high byte and go to LEN_LO.
  - LEN_LO: in_ready=1. On transfer, form N.
    - If N > MAX_WORDS, go to ERR.
    - Else if N = 0, go to CHK.
    - Else go to DATA_HI.
  - DATA_HI: in_ready=1. On transfer, latch the high byte and go to DATA_LO.
  - DATA_LO: in_ready=1. On transfer, latch the low byte and go to WRITE.
  - WRITE: in_ready=0. mem_we=1 for exactly this cycle, with mem_addr=index and mem_wdata={hi,lo}. Increment index. If index+1 = N, go to CHK; else go to DATA_HI.
  - CHK: in_ready=1. On transfer, compare the byte against the running XOR. Match goes to DONE; mismatch goes to ERR.
  - DONE: done=1 for one cycle, then IDLE.
  - ERR: error=1 for one cycle, then IDLE.
- busy = cpu_stall = 1 in every state except IDLE.
- Latency:
  - A write occurs exactly one cycle after the LO byte transfers.
  - Minimum frame time is 3 + 3N + 2 cycles from the start pulse to done.
- The checksum register updates on every transfer except the CHK byte itself.
- mem_addr and mem_wdata hold their last values after WRITE; mem_we is the only qualifier.
- start asserted while busy is ignored and does not restart the load.
- Words already written before an error or reset stay in memory; the loader never rolls them back.
- Reset mid-frame: immediate return to IDLE and all outputs to 0, including a mem_we=0 forced mid-cycle. The next start begins a fresh frame.
- There is no timeout. A stalled host keeps the loader in its current state indefinitely.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHK, DONE, ERR);
  - the constants INSTR_W=16, BYTE_W=8, IMEM_ADDR_W=10, IMEM_DEPTH=1024 (also used by instruction memory and the fetch stage).
- The instruction memory gains a synchronous write port (we, waddr, wdata). This is not part of this block.
- One natural sub-module, word_assembler: it handles the HI/LO byte latch and packs bytes into 16-bit words. The FSM, counter and checksum stay in the top level.

Test Plan:
- Load 7 words (frame 00 07 20 09 20 0A 01 2A 01 2B 01 4B 01 4B 01 6A, then correct CHK), stream back-to-back -> 7 mem_we pulses at addr 0..6 with data 2009, 200A, 012A, 012B, 014B, 014B, 016A; one done pulse; error never asserted; busy low afterwards.
- Zero-length frame 00 00 00 -> no mem_we; done pulses 5 cycles after start.
- Same 7-word frame with CHK XOR 0x01 -> all 7 writes occur; error pulses once; done stays 0.
- Length 04 01 (1025) -> error pulses right after LEN_LO; zero mem_we; next frame with a valid length loads normally.
- Backpressure/gaps: in_valid randomly deasserted on the 7-word frame -> identical writes and done. in_ready is 0 in every WRITE cycle, with no byte loss or duplication. A start pulse mid-frame has no effect.
- Assert rst_n=0 after the third write -> all outputs 0 immediately. After release, a fresh 2-word frame (00 02 AB CD 12 34 CHK) writes addr 0 = ABCD and addr 1 = 1234, then done.
